// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: paces conversions on the MCP3002 SPI engine,
// round-robins across the enabled channels and queues tagged 10-bit
// results in a show-ahead FIFO for the logger.
module adc_sample_sequencer #(
    parameter int PERIOD     = 2400,
    parameter int TIMEOUT    = 255,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [1:0]       i_chan_mask,
    input  logic             i_clear_flags,
    output logic             o_conv_start,
    output logic             o_conv_chan,
    input  logic             i_conv_done,
    input  logic [9:0]       i_conv_data,
    output logic             o_smp_valid,
    input  logic             i_smp_ready,
    output logic [9:0]       o_smp_data,
    output logic             o_smp_chan,
    output logic [CNT_W-1:0] o_fifo_count,
    output logic             o_overflow,
    output logic             o_overrun,
    output logic             o_timeout_err
);

    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
    // Abort is decided in the cycle where the counter shows TIMEOUT-1 so the
    // flag becomes visible exactly TIMEOUT cycles after the start pulse.
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Sticky flag update: a set event wins over a simultaneous clear.
    function automatic logic sticky_next(input logic set_i, input logic clr_i, input logic cur_i);
        if (set_i) begin
            return 1'b1;
        end else if (clr_i) begin
            return 1'b0;
        end else begin
            return cur_i;
        end
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_chan_ptr;
    logic              r_conv_start;
    logic              r_conv_chan;
    logic              r_overflow;
    logic              r_overrun;
    logic              r_timeout_err;
    logic [10:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_tick;
    logic w_sel_chan;
    logic w_issue_go;
    logic w_push;
    logic w_to_fire;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_ovf;
    logic w_ovr;

    assign w_tick     = i_enable && (r_tick_cnt == TICK_LAST);
    // Lowest enabled channel at or after the pointer, wrapping over two channels.
    assign w_sel_chan = i_chan_mask[r_chan_ptr] ? r_chan_ptr : ~r_chan_ptr;
    assign w_issue_go = (r_state == S_WAIT_TICK) && (w_next_state == S_ISSUE);
    assign w_ovr      = w_tick && ((r_state == S_ISSUE) || (r_state == S_WAIT_DONE));

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_pop   = !w_empty && i_smp_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovf   = w_push && w_full && !w_pop;

    // Sample-rate counter: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
        end else if (!i_enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Next-state decode plus FIFO-push and timeout-abort strobes.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_to_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next_state = S_WAIT_TICK;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_TICK: begin
                if (!i_enable) begin
                    w_next_state = S_IDLE;
                end else if (w_tick && (i_chan_mask != 2'b00)) begin
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_WAIT_TICK;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_conv_done) begin
                    w_push       = 1'b1;
                    w_next_state = i_enable ? S_WAIT_TICK : S_IDLE;
                end else if (r_to_cnt >= TO_LAST) begin
                    w_to_fire    = 1'b1;
                    w_next_state = i_enable ? S_WAIT_TICK : S_IDLE;
                end else begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, registered start pulse/channel, rotation pointer and timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_conv_start <= 1'b0;
            r_conv_chan  <= 1'b0;
            r_chan_ptr   <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_conv_start <= w_issue_go;
            if (w_issue_go) begin
                r_conv_chan <= w_sel_chan;
                r_chan_ptr  <= ~w_sel_chan;
            end else begin
                r_conv_chan <= r_conv_chan;
                r_chan_ptr  <= r_chan_ptr;
            end
            if (r_state == S_ISSUE) begin
                r_to_cnt <= TO_W'(1);
            end else if (r_state == S_WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= r_to_cnt;
            end
        end
    end

    // Sample FIFO storage, pointers and exact occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_conv_chan, i_conv_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow    <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overflow    <= sticky_next(w_ovf, i_clear_flags, r_overflow);
            r_overrun     <= sticky_next(w_ovr, i_clear_flags, r_overrun);
            r_timeout_err <= sticky_next(w_to_fire, i_clear_flags, r_timeout_err);
        end
    end

    assign o_conv_start  = r_conv_start;
    assign o_conv_chan   = r_conv_chan;
    assign o_smp_valid   = !w_empty;
    assign o_smp_data    = r_mem[r_rd_ptr][9:0];
    assign o_smp_chan    = r_mem[r_rd_ptr][10];
    assign o_fifo_count  = r_count;
    assign o_overflow    = r_overflow;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
Paces and sequences conversions on the MCP3002 SPI engine. It issues a start request at a programmable sample rate and round-robins across the enabled ADC channels (0/1). Each 10-bit result is tagged with its channel and queued in a small show-ahead FIFO for the data-logger storage path. It sits between the SPI engine (conv_* handshake) and the logger (smp_* valid/ready).

Parameters:
PERIOD, 2400, sample-tick period in clk cycles; minimum 2
TIMEOUT, 255, max clk cycles from conv_start to conv_done before abort; minimum 1
FIFO_DEPTH, 8, sample FIFO entries; power of 2, minimum 2
CNT_W, 4, width of fifo_count; must be log2(FIFO_DEPTH)+1

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = run the sampling schedule
chan_mask  in  2  bit n = 1 means channel n is in the rotation
clear_flags  in  1  clears the sticky flags
conv_start  out  1  one-cycle request to the SPI engine
conv_chan  out  1  channel for the current conversion
conv_done  in  1  one-cycle pulse; conv_data is valid in this cycle
conv_data  in  10  conversion result
smp_valid  out  1  FIFO not empty
smp_ready  in  1  consumer accepts the head entry
smp_data  out  10  head sample
smp_chan  out  1  head channel tag
fifo_count  out  CNT_W  occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: a sample was dropped because the FIFO was full
overrun  out  1  sticky: a tick arrived while a conversion was in flight
timeout_err  out  1  sticky: conv_done did not arrive within TIMEOUT

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE, tick counter 0, channel pointer 0, FIFO empty. All outputs are 0: conv_start, conv_chan, smp_valid, smp_data, smp_chan, fifo_count and all flags.
- Tick counter:
  - While enable=1 it counts 0..PERIOD-1 and wraps.
  - tick=1 when count==PERIOD-1.
  - While enable=0 it is held at 0.
  - The first tick comes PERIOD cycles after enable rises.
- FSM states: IDLE, WAIT_TICK, ISSUE, WAIT_DONE.
  - IDLE: go to WAIT_TICK when enable=1.
  - WAIT_TICK:
    - if enable=0, go to IDLE.
    - else on tick with chan_mask!=0, go to ISSUE.
    - chan_mask==0: ticks are ignored and no flag is set.
  - ISSUE (exactly 1 cycle):
    - conv_start=1.
    - conv_chan = selected channel: the lowest enabled channel at or after the pointer, wrapping.
    - Pointer advances to selected+1 mod 2.
    - Go to WAIT_DONE.
  - WAIT_DONE:
    - conv_chan is held stable and the timeout counter increments each cycle.
    - On conv_done: write {conv_chan, conv_data} to the FIFO. Go to WAIT_TICK if enable=1, else IDLE.
    - If the timeout counter reaches TIMEOUT with no done: set timeout_err, write nothing, go to WAIT_TICK/IDLE by the same enable rule.
    - conv_done outside WAIT_DONE is ignored.
  - A tick in ISSUE or WAIT_DONE sets overrun. The tick is dropped, not queued.
  - enable falling during ISSUE/WAIT_DONE does not abort: the conversion completes and is stored.
- FIFO: registered write; show-ahead read.
  - Latency: conv_done at cycle N gives smp_valid=1 and the data at cycle N+1 (FIFO previously empty).
  - Pop when smp_valid & smp_ready; the next entry is visible the next cycle.
  - Push when full without a same-cycle pop: the sample is dropped, overflow is set, and FIFO contents are unchanged.
  - Push when full with a same-cycle pop: both happen and fifo_count stays FIFO_DEPTH.
  - Push and pop when empty: push only (smp_valid was 0).
  - Pointers wrap mod FIFO_DEPTH. fifo_count is exact.
- Sticky flags: clear_flags=1 clears them next cycle. A set event in the same cycle takes priority, so the flag stays 1.
- rst mid-conversion returns to the reset state immediately. A later conv_done from the engine is ignored (FSM is not in WAIT_DONE).

Test Plan:
1. PERIOD=10, chan_mask=2'b11, enable=1, engine returns done 5 cycles after start with data 0x155/0x2AA, smp_ready=1 -> conv_start every 10 cycles; conv_chan 0,1,0,1; outputs (0,0x155),(1,0x2AA) alternating, each one cycle after done.
2. chan_mask=2'b10 -> every conv_chan=1. Then chan_mask=2'b00 -> no conv_start for 50 cycles and no flags set.
3. smp_ready=0, FIFO_DEPTH=8, 10 completed conversions -> fifo_count=8, overflow=1, and the head is still the first sample. Then smp_ready=1 -> 8 samples drain in order and fifo_count reaches 0.
4. Engine never asserts done, TIMEOUT=20 -> timeout_err=1 exactly 20 cycles after start, no FIFO write, the next tick still issues conv_start.
5. PERIOD=10 with done delayed 15 cycles -> overrun=1 and the sample is still stored. Pulse clear_flags with no new event -> overrun=0.
6. Assert rst during WAIT_DONE, then pulse conv_done -> every output is 0 and fifo_count stays 0. Drop enable during WAIT_DONE -> the sample is stored, the FSM goes to IDLE, and no further conv_start occurs.
